// File: rtl/cs_negate_pipe.sv
// cs_negate_pipe: optional negation of a carry-save operand pair, followed by a
// two-entry output buffer (OUT + SKID) with a registered in_ready. The negation
// is either a full two's complement, or a ones' complement that reports the
// deferred +1 count on out_inc so a downstream adder can absorb it as carry-in.
module cs_negate_pipe #(
    parameter int WIDTH     = 50,
    parameter bit DEFER_INC = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_P,
    input  logic [WIDTH-1:0] in_C,
    input  logic [1:0]       two_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_P,
    output logic [WIDTH-1:0] out_C,
    output logic [1:0]       out_inc
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             deliver;
    logic             load_out_in;
    logic             load_out_skid;
    logic             load_skid;

    logic [WIDTH-1:0] proc_p;
    logic [WIDTH-1:0] proc_c;
    logic [1:0]       proc_inc;

    logic [WIDTH-1:0] out_p_q;
    logic [WIDTH-1:0] out_c_q;
    logic [1:0]       out_inc_q;
    logic [WIDTH-1:0] skid_p_q;
    logic [WIDTH-1:0] skid_c_q;
    logic [1:0]       skid_inc_q;

    // in_ready is a flop, so accept never depends combinationally on out_ready.
    assign accept    = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign deliver   = out_valid && out_ready;

    // Negate the incoming operands before they reach any register.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block leaves a value unassigned and no latch is inferred.
        proc_p   = in_P;
        proc_c   = in_C;
        proc_inc = 2'd0;
        if (two_en[0]) begin
            proc_p = DEFER_INC ? ~in_P : (~in_P + LSB_ONE);
        end
        if (two_en[1]) begin
            proc_c = DEFER_INC ? ~in_C : (~in_C + LSB_ONE);
        end
        if (DEFER_INC) begin
            proc_inc = {1'b0, two_en[0]} + {1'b0, two_en[1]};
        end
    end

    // Buffer occupancy: next state and which register loads on this edge.
    always_comb begin
        next_state    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state  = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    load_out_in = 1'b1;
                end else if (deliver) begin
                    next_state = EMPTY;
                end else if (accept) begin
                    next_state = TWO;
                    load_skid  = 1'b1;
                end
            end
            TWO: begin
                // in_ready is low here, so only a deliver can happen.
                if (deliver) begin
                    next_state    = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // State register and registered in_ready; reset wins over accept/deliver.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != TWO);
        end
    end

    // OUT register: loaded from the arithmetic or from SKID, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p_q   <= '0;
            out_c_q   <= '0;
            out_inc_q <= 2'd0;
        end else if (load_out_in) begin
            out_p_q   <= proc_p;
            out_c_q   <= proc_c;
            out_inc_q <= proc_inc;
        end else if (load_out_skid) begin
            out_p_q   <= skid_p_q;
            out_c_q   <= skid_c_q;
            out_inc_q <= skid_inc_q;
        end
    end

    // SKID register: catches the beat accepted while OUT is stalled.
    always_ff @(posedge clk) begin
        // NOTE: SKID data carries no reset; its contents are only read in state
        // TWO, which reset clears, so stale values can never reach the output.
        if (load_skid) begin
            skid_p_q   <= proc_p;
            skid_c_q   <= proc_c;
            skid_inc_q <= proc_inc;
        end
    end

    assign out_P   = out_p_q;
    assign out_C   = out_c_q;
    assign out_inc = out_inc_q;

endmodule

// File: tb/tb_cs_negate_pipe.sv
// Directed bench for cs_negate_pipe at WIDTH=8. Two instances share the input
// stimulus: one with full two's complement, one with deferred increment.
module tb_cs_negate_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_P;
    logic [7:0] in_C;
    logic [1:0] two_en;

    logic       f_in_ready, f_out_valid;
    logic [7:0] f_out_P, f_out_C;
    logic [1:0] f_out_inc;
    logic       d_in_ready, d_out_valid;
    logic [7:0] d_out_P, d_out_C;
    logic [1:0] d_out_inc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cs_negate_pipe #(.WIDTH(8), .DEFER_INC(1'b0)) u_full (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f_in_ready),
        .in_P(in_P), .in_C(in_C), .two_en(two_en),
        .out_valid(f_out_valid), .out_ready(out_ready),
        .out_P(f_out_P), .out_C(f_out_C), .out_inc(f_out_inc)
    );

    cs_negate_pipe #(.WIDTH(8), .DEFER_INC(1'b1)) u_defer (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_P(in_P), .in_C(in_C), .two_en(two_en),
        .out_valid(d_out_valid), .out_ready(out_ready),
        .out_P(d_out_P), .out_C(d_out_C), .out_inc(d_out_inc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then observed on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One isolated beat with out_ready high; checks both instances, then drains.
    task automatic beat(input string tag, input logic [7:0] p, input logic [7:0] c,
                        input logic [1:0] en,
                        input logic [7:0] fp, input logic [7:0] fc,
                        input logic [7:0] dp, input logic [7:0] dc, input logic [1:0] dinc);
        logic [7:0] dsum;
        in_P      = p;
        in_C      = c;
        two_en    = en;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        check({tag, " full valid"}, 32'(f_out_valid), 32'd1);
        check({tag, " full P"},     32'(f_out_P),     32'(fp));
        check({tag, " full C"},     32'(f_out_C),     32'(fc));
        check({tag, " full inc"},   32'(f_out_inc),   32'd0);
        check({tag, " defer P"},    32'(d_out_P),     32'(dp));
        check({tag, " defer C"},    32'(d_out_C),     32'(dc));
        check({tag, " defer inc"},  32'(d_out_inc),   32'(dinc));
        dsum = d_out_P + d_out_C + 8'(d_out_inc);
        check({tag, " defer sum"},  32'(dsum),        32'(8'(fp + fc)));
        in_valid = 1'b0;
        cycle();
        check({tag, " drained"},    32'(f_out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_P      = 8'h00;
        in_C      = 8'h00;
        two_en    = 2'b00;

        // Reset state.
        cycle();
        cycle();
        check("rst out_valid", 32'(f_out_valid), 32'd0);
        check("rst in_ready",  32'(f_in_ready),  32'd0);
        check("rst out_P",     32'(f_out_P),     32'd0);
        check("rst out_C",     32'(f_out_C),     32'd0);
        check("rst out_inc",   32'(d_out_inc),   32'd0);
        rst = 1'b0;
        cycle();
        check("post-rst in_ready",  32'(f_in_ready),  32'd1);
        check("post-rst out_valid", 32'(f_out_valid), 32'd0);

        // Arithmetic, both modes.       full P/C       defer P/C/inc
        beat("neg P",    8'h05, 8'h03, 2'b01, 8'hFB, 8'h03, 8'hFA, 8'h03, 2'd1);
        beat("neg PC",   8'h05, 8'h03, 2'b11, 8'hFB, 8'hFD, 8'hFA, 8'hFC, 2'd2);
        beat("boundary", 8'h00, 8'h80, 2'b11, 8'h00, 8'h80, 8'hFF, 8'h7F, 2'd2);
        beat("neg C",    8'h12, 8'h01, 2'b10, 8'h12, 8'hFF, 8'h12, 8'hFE, 2'd1);
        beat("pass",     8'hAA, 8'h55, 2'b00, 8'hAA, 8'h55, 8'hAA, 8'h55, 2'd0);

        // Backpressure: A to OUT, B to SKID, C held off.
        out_ready = 1'b0;
        two_en    = 2'b00;
        in_valid  = 1'b1;
        in_P = 8'h01; in_C = 8'h02;
        cycle();
        check("bp A out_P",    32'(f_out_P),    32'h01);
        check("bp A in_ready", 32'(f_in_ready), 32'd1);
        in_P = 8'h03; in_C = 8'h04;
        cycle();
        check("bp B in_ready", 32'(f_in_ready), 32'd0);
        check("bp B out_P",    32'(f_out_P),    32'h01);
        in_P = 8'h05; in_C = 8'h06;
        cycle();
        check("bp C held in_ready", 32'(f_in_ready), 32'd0);
        check("bp C held out_P",    32'(f_out_P),    32'h01);
        check("bp C held out_C",    32'(f_out_C),    32'h02);
        out_ready = 1'b1;
        cycle();
        check("bp deliver B", 32'(f_out_P), 32'h03);
        check("bp B out_C",   32'(f_out_C), 32'h04);
        cycle();
        check("bp deliver C", 32'(f_out_P), 32'h05);
        in_valid = 1'b0;
        cycle();
        check("bp drained", 32'(f_out_valid), 32'd0);

        // Streaming: 16 back-to-back beats, no bubbles.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        two_en    = 2'b01;
        for (int i = 0; i < 16; i++) begin
            in_P = 8'(i);
            in_C = 8'(3 * i);
            cycle();
            check($sformatf("stream %0d valid", i),    32'(f_out_valid), 32'd1);
            check($sformatf("stream %0d full P", i),   32'(f_out_P),     32'(8'(8'd0 - 8'(i))));
            check($sformatf("stream %0d defer P", i),  32'(d_out_P),     32'(8'(8'hFF - 8'(i))));
            check($sformatf("stream %0d C", i),        32'(f_out_C),     32'(8'(3 * i)));
        end
        in_valid = 1'b0;
        cycle();
        check("stream drained", 32'(f_out_valid), 32'd0);

        // Reset while TWO entries are held.
        out_ready = 1'b0;
        two_en    = 2'b00;
        in_valid  = 1'b1;
        in_P = 8'h77; in_C = 8'h11;
        cycle();
        in_P = 8'h88; in_C = 8'h22;
        cycle();
        check("mid-rst full in_ready", 32'(f_in_ready), 32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("mid-rst out_valid", 32'(f_out_valid), 32'd0);
        check("mid-rst in_ready",  32'(f_in_ready),  32'd0);
        check("mid-rst out_P",     32'(f_out_P),     32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        cycle();
        check("after rst in_ready",  32'(f_in_ready),  32'd1);
        check("after rst no stale",  32'(f_out_valid), 32'd0);
        cycle();
        check("after rst still empty", 32'(d_out_valid), 32'd0);
        beat("after rst", 8'h21, 8'h43, 2'b00, 8'h21, 8'h43, 8'h21, 8'h43, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cs_negate_pipe.md
CS_NEGATE_PIPE -- requirements
Module: cs_negate_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 50, bit width of each carry-save operand.
REQ-002 SHALL have parameter: DEFER_INC, 0, where 0 = full two's complement in block and 1 = ones' complement with deferred increment count.
REQ-003 SHALL have a single clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-004 SHALL have port: clk  input  1  clock.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: in_valid  input  1  input beat present.
REQ-007 SHALL have port: in_ready  output  1  block can accept a beat.
REQ-008 SHALL have port: in_P  input  WIDTH  partial-sum operand.
REQ-009 SHALL have port: in_C  input  WIDTH  carry operand.
REQ-010 SHALL have port: two_en  input  2  bit0 negates P, bit1 negates C.
REQ-011 SHALL have port: out_valid  output  1  output beat present.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts the beat.
REQ-013 SHALL have port: out_P  output  WIDTH  processed P.
REQ-014 SHALL have port: out_C  output  WIDTH  processed C.
REQ-015 SHALL have port: out_inc  output  2  deferred +1 count, range 0..2.

Function
REQ-016 SHALL accept an input beat on a clock edge where in_valid && in_ready, capturing in_P, in_C and two_en.
REQ-017 SHALL deliver an output beat on a clock edge where out_valid && out_ready.
REQ-018 SHALL process operands per beat: for each operand with its two_en bit set, DEFER_INC=0 gives (~x + 1) mod 2^WIDTH and DEFER_INC=1 gives ~x; an operand with its bit clear passes unchanged.
REQ-019 SHALL drive out_inc to 0 when DEFER_INC=0, and to two_en[0] + two_en[1] when DEFER_INC=1.
REQ-020 SHALL keep the invariant that out_P + out_C + out_inc equals the intended signed sum mod 2^WIDTH in both modes.
REQ-021 SHALL treat the boundary operands per REQ-018 arithmetic: negating 0 yields 0; negating 1 followed by WIDTH-1 zeros yields the same value; both cases raise no flag and carry no extra state.
REQ-022 SHALL have latency 1: a beat accepted at edge N presents out_valid at edge N+1 if the output stage is empty or drains at N.
REQ-023 SHALL support a throughput of one beat per cycle while out_ready is held high.
REQ-024 SHALL buffer with two entries, an output register (OUT) and a skid register (SKID); state is EMPTY (no entries), ONE (OUT full), or TWO (OUT and SKID full).
REQ-025 SHALL go EMPTY -> ONE on accept.
REQ-026 SHALL stay in ONE on accept with deliver, with the new beat loaded into OUT.
REQ-027 SHALL go ONE -> EMPTY on deliver without accept.
REQ-028 SHALL go ONE -> TWO on accept without deliver, with the new beat loaded into SKID.
REQ-029 SHALL go TWO -> ONE on deliver, with SKID moved to OUT; no accept is possible in TWO.
REQ-030 SHALL drive in_ready registered, high exactly when state is not TWO, with no combinational path from out_ready.
REQ-031 SHALL drive out_valid high exactly when state is ONE or TWO.
REQ-032 SHALL hold out_P, out_C and out_inc stable while out_valid && !out_ready.
REQ-033 SHALL deliver beats strictly in acceptance order, with no beat dropped or duplicated.
REQ-034 SHALL ignore input data while in_ready is low, and ignore in_valid while in_ready is low.
REQ-035 SHALL perform the arithmetic before the register, leaving no combinational path from inputs to out_*.

Reset
REQ-036 SHALL, while rst is high at an edge, set state EMPTY, out_valid=0, in_ready=0, and out_P=out_C=0, out_inc=0.
REQ-037 SHALL drive in_ready=1 on the first edge after rst deasserts.
REQ-038 SHALL discard any beat held in OUT or SKID when reset is asserted mid-operation, so that no stale beat appears after reset.
REQ-039 SHALL give rst priority over a simultaneous accept or deliver.

Verification (WIDTH=8 unless stated)
REQ-040 SHALL cover DEFER_INC=0 with P=0x05, C=0x03, two_en=01, out_ready=1: the next cycle gives out_P=0xFB, out_C=0x03, out_inc=0, out_valid=1.
REQ-041 SHALL cover DEFER_INC=1 with P=0x05, C=0x03, two_en=11: the response is out_P=0xFA, out_C=0xFC, out_inc=2, and 0xFA+0xFC+2 mod 256 = 0xF8 = -(8).
REQ-042 SHALL cover the boundary case two_en=11 with P=0x00, C=0x80, DEFER_INC=0: the response is out_P=0x00, out_C=0x80.
REQ-043 SHALL cover backpressure: beats A, B, C offered back-to-back with out_ready=0 give A in OUT, B in SKID, in_ready=0 after the second accept and C held; then out_ready=1 delivers A, B, C in order on consecutive cycles.
REQ-044 SHALL cover streaming: 16 beats with out_ready=1 and in_valid=1 continuously show out_valid high on every cycle after the first, with no gaps.
REQ-045 SHALL cover reset mid-operation: rst pulsed with state TWO gives out_valid=0 and in_ready=0 during reset, then in_ready=1 with no stale beat delivered.
